tl_ul_reg_bridge: RTL and testbench

TL_UL_REG_BRIDGE -- requirements
Module: tl_ul_reg_bridge

---
 rtl/tl_ul_pkg.sv | 70 +++++++
 rtl/tl_ul_reg_bridge_if.sv | 47 ++++
 rtl/tl_ul_reg_bridge.sv | 192 +++++++++++++++++++
 tb/tb_tl_ul_reg_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// ---------------------------------------------------------------------------
// tl_ul_pkg
// Shared definitions for the TL-UL to register-port bridge:
//   - A-channel and D-channel opcode encodings
//   - bridge FSM state type
//   - TIMEOUT_CYCLES, the ACCESS-phase limit used when the bridge is built
//     with REG_BRIDGE_TIMEOUT_EN
//   - req_legal(), the A-beat legality rule shared by the bridge
// ---------------------------------------------------------------------------
package tl_ul_pkg;

    typedef enum logic [2:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_GET         = 3'd4
    } a_opcode_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1
    } d_opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES = 255;

    // A beat is legal when the opcode is known, the size fits a 32-bit word,
    // the address is naturally aligned to the size, and a PutFullData mask
    // covers every byte lane the size/offset touches.
    function automatic logic req_legal(
        input logic [2:0] opcode,
        input logic [2:0] size,
        input logic [1:0] addr_lo,
        input logic [3:0] mask
    );
        logic       op_ok;
        logic       size_ok;
        logic       align_ok;
        logic       mask_ok;
        logic [3:0] lanes;

        op_ok   = (opcode == A_PUT_FULL) || (opcode == A_PUT_PARTIAL) ||
                  (opcode == A_GET);
        size_ok = (size <= 3'd2);

        unique case (size)
            3'd0: begin
                align_ok = 1'b1;
                lanes    = 4'b0001 << addr_lo;
            end
            3'd1: begin
                align_ok = ~addr_lo[0];
                lanes    = 4'b0011 << addr_lo;
            end
            default: begin
                align_ok = (addr_lo == 2'b00);
                lanes    = 4'b1111;
            end
        endcase

        mask_ok = (opcode != A_PUT_FULL) || ((mask & lanes) == lanes);

        return op_ok && size_ok && align_ok && mask_ok;
    endfunction

endpackage

// File: rtl/tl_ul_reg_bridge_if.sv
// ---------------------------------------------------------------------------
// tl_ul_reg_bridge_if
// TL-UL A/D channel bundle feeding the register bridge.
//   Parameter SRC_W : width of a_source / d_source
//   A channel : a_valid, a_ready, a_opcode, a_size, a_source, a_address,
//               a_mask, a_data
//   D channel : d_valid, d_ready, d_opcode, d_size, d_source, d_denied,
//               d_data
// Modports:
//   master : TL requester (drives A beats, accepts D responses)
//   slave  : the bridge (accepts A beats, returns D responses)
// ---------------------------------------------------------------------------
interface tl_ul_reg_bridge_if #(
    parameter int unsigned SRC_W = 1
);
    logic             a_valid;
    logic             a_ready;
    logic [2:0]       a_opcode;
    logic [2:0]       a_size;
    logic [SRC_W-1:0] a_source;
    logic [31:0]      a_address;
    logic [3:0]       a_mask;
    logic [31:0]      a_data;

    logic             d_valid;
    logic             d_ready;
    logic [2:0]       d_opcode;
    logic [2:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic             d_denied;
    logic [31:0]      d_data;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_size, d_source, d_denied, d_data,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_size, d_source, d_denied, d_data,
        input  d_ready
    );

endinterface

// File: rtl/tl_ul_reg_bridge.sv
// ---------------------------------------------------------------------------
// tl_ul_reg_bridge
// Converts single TL-UL transactions into a simple request/ack register port.
// One transaction is in flight at a time: IDLE accepts an A beat, ACCESS
// holds reg_req until reg_ack, RESP holds the D response until d_ready.
// Illegal A beats skip ACCESS and are answered with d_denied=1.
//
// Ports:
//   clock     : sole clock, rising edge
//   reset_n   : asynchronous active-low reset
//   tl        : TL-UL A/D channels (tl_ul_reg_bridge_if.slave)
//   reg_req   : register access strobe, held until reg_ack
//   reg_we    : 1=write, 0=read
//   reg_addr  : word address (a_address[31:2])
//   reg_be    : byte enables (a_mask for Put, 4'hF for Get)
//   reg_wdata : write data
//   reg_ack   : access complete, reg_rdata/reg_err valid this cycle
//   reg_rdata : read data
//   reg_err   : slave error
//
// Build option:
//   REG_BRIDGE_TIMEOUT_EN : abort an access after TIMEOUT_CYCLES cycles
//   without reg_ack and return d_denied=1. Undefined: ACCESS waits forever.
// ---------------------------------------------------------------------------
module tl_ul_reg_bridge
    import tl_ul_pkg::*;
#(
    parameter int unsigned SRC_W = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    tl_ul_reg_bridge_if.slave    tl,
    output logic                 reg_req,
    output logic                 reg_we,
    output logic [29:0]          reg_addr,
    output logic [3:0]           reg_be,
    output logic [31:0]          reg_wdata,
    input  logic                 reg_ack,
    input  logic [31:0]          reg_rdata,
    input  logic                 reg_err
);

    state_e           state_q;
    state_e           state_d;

    logic [2:0]       opcode_q;
    logic [2:0]       size_q;
    logic [SRC_W-1:0] src_q;
    logic [29:0]      addr_q;
    logic [3:0]       mask_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             denied_q;

    logic             accept;
    logic             a_legal;
    logic             ack_taken;
    logic             is_get;
    logic             timeout_hit;

    assign a_legal   = req_legal(tl.a_opcode, tl.a_size, tl.a_address[1:0],
                                 tl.a_mask);
    assign accept    = tl.a_valid && (state_q == ST_IDLE);
    // reg_ack only counts while an access is outstanding
    assign ack_taken = reg_ack && (state_q == ST_ACCESS);
    assign is_get    = (opcode_q == A_GET);

`ifdef REG_BRIDGE_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    // Counts completed ACCESS cycles; zero on entry to ACCESS, so the
    // TIMEOUT_CYCLES-th cycle without ack sees TIMEOUT_CYCLES-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != ST_ACCESS) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    assign timeout_hit = (state_q == ST_ACCESS) && !reg_ack &&
                         (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // -----------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------
    // Next state and output decode. All bus outputs are qualified by
    // state so that they read 0 while no phase owns them (including
    // while reset_n is low).
    // -----------------------------------------------------------------
    always_comb begin
        state_d     = state_q;

        tl.a_ready  = 1'b0;
        tl.d_valid  = 1'b0;
        tl.d_opcode = D_ACCESS_ACK;
        tl.d_size   = '0;
        tl.d_source = '0;
        tl.d_denied = 1'b0;
        tl.d_data   = '0;

        reg_req     = 1'b0;
        reg_we      = 1'b0;
        reg_addr    = '0;
        reg_be      = '0;
        reg_wdata   = '0;

        unique case (state_q)
            ST_IDLE: begin
                tl.a_ready = 1'b1;
                if (accept) begin
                    state_d = a_legal ? ST_ACCESS : ST_RESP;
                end
            end

            ST_ACCESS: begin
                reg_req   = 1'b1;
                reg_we    = !is_get;
                reg_addr  = addr_q;
                reg_be    = is_get ? 4'hF : mask_q;
                reg_wdata = wdata_q;
                if (ack_taken || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                tl.d_valid  = 1'b1;
                tl.d_opcode = is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
                tl.d_size   = size_q;
                tl.d_source = src_q;
                tl.d_denied = denied_q;
                tl.d_data   = (is_get && !denied_q) ? rdata_q : '0;
                if (tl.d_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------
    // Transaction context: captured on accept, completed on ack/timeout
    // -----------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q <= '0;
            size_q   <= '0;
            src_q    <= '0;
            addr_q   <= '0;
            mask_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            denied_q <= 1'b0;
        end else if (accept) begin
            opcode_q <= tl.a_opcode;
            size_q   <= tl.a_size;
            src_q    <= tl.a_source;
            addr_q   <= tl.a_address[31:2];
            mask_q   <= tl.a_mask;
            wdata_q  <= tl.a_data;
            rdata_q  <= '0;
            denied_q <= !a_legal;
        end else if (ack_taken) begin
            denied_q <= reg_err;
            if (is_get) begin
                rdata_q <= reg_rdata;
            end
        end else if (timeout_hit) begin
            denied_q <= 1'b1;
            rdata_q  <= '0;
        end
    end

endmodule

// File: tb/tb_tl_ul_reg_bridge.sv
module tb_tl_ul_reg_bridge;
    localparam int unsigned SRC_W = 1;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    tl_ul_reg_bridge_if #(.SRC_W(SRC_W)) tl ();

    logic        reg_req;
    logic        reg_we;
    logic [29:0] reg_addr;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        reg_err;

    tl_ul_reg_bridge #(.SRC_W(SRC_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .tl        (tl),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_be    (reg_be),
        .reg_wdata (reg_wdata),
        .reg_ack   (reg_ack),
        .reg_rdata (reg_rdata),
        .reg_err   (reg_err)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned lat;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic             m_busy  = 1'b0;
    logic             m_legal = 1'b0;
    logic             m_acked = 1'b0;
    logic             m_tmo   = 1'b0;
    logic             m_err   = 1'b0;
    logic [2:0]       m_op    = '0;
    logic [2:0]       m_size  = '0;
    logic [SRC_W-1:0] m_src   = '0;
    logic [31:0]      m_addr  = '0;
    logic [31:0]      m_wdata = '0;
    logic [31:0]      m_rdata = '0;
    logic [3:0]       m_mask  = '0;
    int unsigned      m_wait  = 0;

    function automatic logic spec_legal(input logic [2:0] op, input logic [2:0] size,
                                        input logic [31:0] addr, input logic [3:0] mask);
        int unsigned nbytes;
        int unsigned need;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b0;
        if (size > 3'd2) return 1'b0;
        nbytes = 1 << size;
        if ((addr % nbytes) != 0) return 1'b0;
        if (op == 3'd0) begin
            need = ((1 << nbytes) - 1) << (addr % 4);
            if ((int'(mask) & need) != need) return 1'b0;
        end
        return 1'b1;
    endfunction

    logic        exp_req;
    logic        exp_dv;
    logic        exp_get;
    logic        exp_denied;
    logic [31:0] exp_data;
    assign exp_req    = m_busy && m_legal && !m_acked && !m_tmo;
    assign exp_dv     = m_busy && !exp_req;
    assign exp_get    = (m_op == 3'd4);
    assign exp_denied = !m_legal || m_err || m_tmo;
    assign exp_data   = (exp_get && !exp_denied) ? m_rdata : 32'h0;

    // Model sees only bench-driven inputs; its own a_ready is !m_busy.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_acked <= 1'b0;
            m_tmo  <= 1'b0;
        end else if (!m_busy) begin
            if (tl.a_valid) begin
                m_busy  <= 1'b1;
                m_op    <= tl.a_opcode;
                m_size  <= tl.a_size;
                m_src   <= tl.a_source;
                m_addr  <= tl.a_address;
                m_mask  <= tl.a_mask;
                m_wdata <= tl.a_data;
                m_legal <= spec_legal(tl.a_opcode, tl.a_size, tl.a_address, tl.a_mask);
                m_acked <= 1'b0;
                m_tmo   <= 1'b0;
                m_err   <= 1'b0;
                m_rdata <= '0;
                m_wait  <= 0;
            end
        end else if (exp_req) begin
            if (reg_ack) begin
                m_acked <= 1'b1;
                m_err   <= reg_err;
                m_rdata <= reg_rdata;
            end else begin
                m_wait <= m_wait + 1;
`ifdef REG_BRIDGE_TIMEOUT_EN
                if (m_wait + 1 == 255) m_tmo <= 1'b1;
`endif
            end
        end else if (tl.d_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clock) begin
        chk("a_ready", tl.a_ready, !m_busy);
        chk("reg_req", reg_req, exp_req);
        chk("d_valid", tl.d_valid, exp_dv);
        if (exp_req) begin
            chk("reg_we", reg_we, !exp_get);
            chk("reg_addr", reg_addr, m_addr[31:2]);
            chk("reg_be", reg_be, exp_get ? 4'hF : m_mask);
            if (!exp_get) chk("reg_wdata", reg_wdata, m_wdata);
        end
        if (exp_dv) begin
            if (m_op == 3'd0 || m_op == 3'd1 || m_op == 3'd4)
                chk("d_opcode", tl.d_opcode, exp_get ? 3'd1 : 3'd0);
            chk("d_size", tl.d_size, m_size);
            chk("d_source", tl.d_source, m_src);
            chk("d_denied", tl.d_denied, exp_denied);
            chk("d_data", tl.d_data, exp_data);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send_a(input logic [2:0] op, input logic [2:0] size,
                          input logic [SRC_W-1:0] src, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data);
        logic rdy = 1'b0;
        tl.a_opcode = op; tl.a_size = size; tl.a_source = src;
        tl.a_address = addr; tl.a_mask = mask; tl.a_data = data;
        tl.a_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (tl.a_ready) begin rdy = 1'b1; break; end
            @(posedge clock); #1;
        end
        chk("a_accept_bound", rdy, 1'b1);
        @(posedge clock); #1;
        tl.a_valid = 1'b0;
        lat = 1;
    endtask

    task automatic reg_phase(input int unsigned delay, input logic [31:0] rdata, input logic err);
        repeat (delay) begin @(posedge clock); #1; lat++; end
        chk("req_at_ack", reg_req, 1'b1);
        reg_ack = 1'b1; reg_rdata = rdata; reg_err = err;
        @(posedge clock); #1; lat++;
        reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
    endtask

    task automatic d_phase(input int unsigned stall, input int unsigned exp_lat, input int exp_op,
                           input logic exp_den, input logic [31:0] exp_d,
                           input logic [2:0] exp_sz, input logic [SRC_W-1:0] exp_src);
        logic seen = 1'b0;
        tl.d_ready = (stall == 0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (tl.d_valid) begin seen = 1'b1; break; end
            @(posedge clock); #1; lat++;
        end
        chk("d_valid_bound", seen, 1'b1);
        if (seen) begin
            chk("latency", lat, exp_lat);
            if (exp_op >= 0) chk("lit_d_opcode", tl.d_opcode, exp_op[2:0]);
            chk("lit_d_denied", tl.d_denied, exp_den);
            chk("lit_d_data", tl.d_data, exp_d);
            chk("lit_d_size", tl.d_size, exp_sz);
            chk("lit_d_source", tl.d_source, exp_src);
            if (stall > 0) begin reg_ack = 1'b1; reg_err = 1'b1; reg_rdata = '1; end
            repeat (stall) begin
                @(posedge clock); #1;
                chk("stall_d_valid", tl.d_valid, 1'b1);
                chk("stall_a_ready", tl.a_ready, 1'b0);
                chk("stall_d_denied", tl.d_denied, exp_den);
            end
            reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
            tl.d_ready = 1'b1;
            @(posedge clock); #1;
        end
        tl.d_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        tl.a_valid = 1'b0; tl.a_opcode = '0; tl.a_size = '0; tl.a_source = '0;
        tl.a_address = '0; tl.a_mask = '0; tl.a_data = '0; tl.d_ready = 1'b0;
        reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
        repeat (2) @(posedge clock); #1;
        chk("rst_a_ready", tl.a_ready, 1'b1);
        chk("rst_reg_req", reg_req, 1'b0);
        chk("rst_d_valid", tl.d_valid, 1'b0);
        chk("rst_reg_outs", {reg_we, reg_addr, reg_be, reg_wdata}, '0);
        chk("rst_d_outs", {tl.d_opcode, tl.d_size, tl.d_source, tl.d_denied, tl.d_data}, '0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Get, ack after 3 cycles
        send_a(3'd4, 3'd2, 1'b1, 32'h1000, 4'hF, 32'h0);
        reg_phase(3, 32'hDEADBEEF, 1'b0);
        d_phase(0, 5, 1, 1'b0, 32'hDEADBEEF, 3'd2, 1'b1);

        // PutPartial halfword on upper lanes
        send_a(3'd1, 3'd1, 1'b0, 32'h2002, 4'b1100, 32'hABCD0000);
        chk("pp_reg_req", reg_req, 1'b1);
        chk("pp_reg_we", reg_we, 1'b1);
        chk("pp_reg_addr", reg_addr, 30'h800);
        chk("pp_reg_be", reg_be, 4'b1100);
        chk("pp_reg_wdata", reg_wdata, 32'hABCD0000);
        reg_phase(0, 32'h0, 1'b0);
        d_phase(0, 2, 0, 1'b0, 32'h0, 3'd1, 1'b0);

        // Misaligned Get: denied, no register access
        send_a(3'd4, 3'd2, 1'b0, 32'h3001, 4'hF, 32'h0);
        chk("mis_reg_req", reg_req, 1'b0);
        d_phase(0, 1, 1, 1'b1, 32'h0, 3'd2, 1'b0);

        // Get with reg_err, D stalled 5 cycles, stray reg_ack in RESP
        send_a(3'd4, 3'd2, 1'b1, 32'h4000, 4'hF, 32'h0);
        reg_phase(1, 32'h12345678, 1'b1);
        d_phase(5, 3, 1, 1'b1, 32'h0, 3'd2, 1'b1);

        // PutFull variants
        send_a(3'd0, 3'd2, 1'b0, 32'h5000, 4'hF, 32'h11223344);
        reg_phase(2, 32'h0, 1'b0);
        d_phase(1, 4, 0, 1'b0, 32'h0, 3'd2, 1'b0);
        send_a(3'd0, 3'd2, 1'b0, 32'h5004, 4'b0111, 32'h0);
        d_phase(0, 1, 0, 1'b1, 32'h0, 3'd2, 1'b0);
        send_a(3'd0, 3'd1, 1'b1, 32'h5006, 4'b1100, 32'h55660000);
        reg_phase(0, 32'h0, 1'b0);
        d_phase(0, 2, 0, 1'b0, 32'h0, 3'd1, 1'b1);
        send_a(3'd0, 3'd0, 1'b0, 32'h5005, 4'b0010, 32'h00007700);
        reg_phase(0, 32'h0, 1'b1);
        d_phase(0, 2, 0, 1'b1, 32'h0, 3'd0, 1'b0);
        send_a(3'd0, 3'd0, 1'b1, 32'h5005, 4'b0001, 32'h0);
        d_phase(0, 1, 0, 1'b1, 32'h0, 3'd0, 1'b1);

        // Unknown opcode and oversize Get are denied
        send_a(3'd2, 3'd2, 1'b0, 32'h6000, 4'hF, 32'h0);
        d_phase(0, 1, -1, 1'b1, 32'h0, 3'd2, 1'b0);
        send_a(3'd4, 3'd3, 1'b1, 32'h6000, 4'hF, 32'h0);
        d_phase(0, 1, 1, 1'b1, 32'h0, 3'd3, 1'b1);

        // Halfword Get: full byte enables
        send_a(3'd4, 3'd1, 1'b0, 32'h6002, 4'b1100, 32'h0);
        chk("hg_reg_be", reg_be, 4'hF);
        chk("hg_reg_we", reg_we, 1'b0);
        reg_phase(0, 32'hCAFE0000, 1'b0);
        d_phase(0, 2, 1, 1'b0, 32'hCAFE0000, 3'd1, 1'b0);

        // No accept in the D-handshake cycle
        send_a(3'd4, 3'd2, 1'b0, 32'h3001, 4'hF, 32'h0);
        tl.d_ready = 1'b1;
        tl.a_opcode = 3'd4; tl.a_size = 3'd2; tl.a_source = 1'b1;
        tl.a_address = 32'h7000; tl.a_mask = 4'hF; tl.a_valid = 1'b1;
        chk("hs_a_ready", tl.a_ready, 1'b0);
        @(posedge clock); #1;
        tl.d_ready = 1'b0;
        chk("post_hs_a_ready", tl.a_ready, 1'b1);
        chk("post_hs_d_valid", tl.d_valid, 1'b0);
        @(posedge clock); #1;
        tl.a_valid = 1'b0;
        lat = 1;
        reg_phase(0, 32'h55AA55AA, 1'b0);
        d_phase(0, 2, 1, 1'b0, 32'h55AA55AA, 3'd2, 1'b1);

        // Reset during ACCESS
        send_a(3'd4, 3'd2, 1'b1, 32'h8000, 4'hF, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_acc_reg_req", reg_req, 1'b0);
        chk("rst_acc_a_ready", tl.a_ready, 1'b1);
        repeat (2) @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        send_a(3'd4, 3'd2, 1'b0, 32'h8004, 4'hF, 32'h0);
        reg_phase(0, 32'h0F0F0F0F, 1'b0);
        d_phase(0, 2, 1, 1'b0, 32'h0F0F0F0F, 3'd2, 1'b0);

        // Reset during RESP
        send_a(3'd4, 3'd2, 1'b0, 32'h8001, 4'hF, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("rst_resp_d_valid", tl.d_valid, 1'b0);
        chk("rst_resp_a_ready", tl.a_ready, 1'b1);
        repeat (2) @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Access with no reg_ack
        send_a(3'd4, 3'd2, 1'b1, 32'h9000, 4'hF, 32'h0);
`ifdef REG_BRIDGE_TIMEOUT_EN
        d_phase(0, 256, 1, 1'b1, 32'h0, 3'd2, 1'b1);
`else
        repeat (300) begin @(posedge clock); #1; lat++; end
        chk("wait_reg_req", reg_req, 1'b1);
        chk("wait_d_valid", tl.d_valid, 1'b0);
        reg_phase(0, 32'h13579BDF, 1'b0);
        d_phase(0, 302, 1, 1'b0, 32'h13579BDF, 3'd2, 1'b1);
`endif

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
